// File: rtl/cache_miss_handler.sv
// cache_miss_handler
//   Per-bank miss controller behind the 4-way tag-compare stage. Tracks a
//   tree-PLRU per set, picks a victim on a miss (first Invalid way, else the
//   PLRU way), writes back a dirty victim, fetches the missing line and
//   issues a one-cycle fill write into the tag/meta/data arrays.
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/index/tag      lookup result from the tag-compare stage
//   hit, way_out             hit flag and one-hot hit way
//   tag_cur_state, meta_in   the set's tags and meta (8 bits per way)
//   victim_data_in           victim line data, sampled on miss accept
//   busy                     miss in progress
//   mem_req_*                memory request channel (rw=1 write-back)
//   mem_resp_valid/data      write-back ack / read data
//   fill_*                   one-cycle array write strobe and payload
module cache_miss_handler #(
  parameter int TAG_SIZE   = 20,
  parameter int INDEX_SIZE = 6,
  parameter int LINE_W     = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic [INDEX_SIZE-1:0]        req_index,
  input  logic [TAG_SIZE-1:0]          req_tag,
  input  logic                         hit,
  input  logic [3:0]                   way_out,
  input  logic [TAG_SIZE*4-1:0]        tag_cur_state,
  input  logic [31:0]                  meta_in,
  input  logic [LINE_W-1:0]            victim_data_in,
  output logic                         busy,
  output logic                         mem_req_valid,
  output logic                         mem_req_rw,
  output logic [TAG_SIZE+INDEX_SIZE-1:0] mem_req_addr,
  output logic [LINE_W-1:0]            mem_req_data,
  input  logic                         mem_req_ready,
  input  logic                         mem_resp_valid,
  input  logic [LINE_W-1:0]            mem_resp_data,
  output logic                         fill_valid,
  output logic [3:0]                   fill_way,
  output logic [INDEX_SIZE-1:0]        fill_index,
  output logic [TAG_SIZE-1:0]          fill_tag,
  output logic [LINE_W-1:0]            fill_data,
  output logic [7:0]                   fill_meta
);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WB_REQ     = 3'd1;
  localparam logic [2:0] WB_WAIT    = 3'd2;
  localparam logic [2:0] FILL_REQ   = 3'd3;
  localparam logic [2:0] FILL_WAIT  = 3'd4;
  localparam logic [2:0] FILL_WRITE = 3'd5;
  localparam int SETS = 1 << INDEX_SIZE;

  logic [2:0]            state;
  logic [2:0]            plru [SETS];
  logic [INDEX_SIZE-1:0] idx_q;
  logic [TAG_SIZE-1:0]   tag_q, vtag_q;
  logic [3:0]            vway_q;
  logic                  vdirty_q;
  logic [LINE_W-1:0]     vdata_q, fdata_q;

  // PLRU bits are {b2,b1,b0}; a touch points the tree away from the way used.
  function automatic logic [2:0] touch(input logic [2:0] p, input logic [3:0] w);
    logic [2:0] n;
    n = p;
    if (w[0])      n = {p[2], 2'b11};
    else if (w[1]) n = {p[2], 2'b01};
    else if (w[2]) n = {1'b1, p[1], 1'b0};
    else if (w[3]) n = {1'b0, p[1], 1'b0};
    return n;
  endfunction

  // Victim: lowest Invalid way first, otherwise follow the PLRU tree.
  logic [3:0]          inv, vway;
  logic [2:0]          plru_rd;
  logic [TAG_SIZE-1:0] vtag;
  logic                vdirty;
  always_comb begin
    for (int i = 0; i < 4; i++) inv[i] = (meta_in[8*i +: 4] == 4'd1);
    plru_rd = plru[req_index];
    if (inv[0])           vway = 4'b0001;
    else if (inv[1])      vway = 4'b0010;
    else if (inv[2])      vway = 4'b0100;
    else if (inv[3])      vway = 4'b1000;
    else if (!plru_rd[0]) vway = plru_rd[1] ? 4'b0010 : 4'b0001;
    else                  vway = plru_rd[2] ? 4'b1000 : 4'b0100;
    vtag   = '0;
    vdirty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (vway[i]) begin
        vtag   = vtag | tag_cur_state[TAG_SIZE*i +: TAG_SIZE];
        vdirty = vdirty | (meta_in[8*i +: 4] == 4'd3);
      end
    end
  end

  // Upper meta nibbles carry fields this block does not act on.
  logic unused_meta;
  assign unused_meta = ^{meta_in[31:28], meta_in[23:20], meta_in[15:12], meta_in[7:4]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) plru[s] <= 3'b000;
    end else if (state == IDLE && req_valid && hit) begin
      plru[req_index] <= touch(plru[req_index], way_out);
    end else if (state == FILL_WRITE) begin
      plru[idx_q] <= touch(plru[idx_q], vway_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx_q    <= '0;
      tag_q    <= '0;
      vtag_q   <= '0;
      vway_q   <= '0;
      vdirty_q <= 1'b0;
      vdata_q  <= '0;
      fdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid && !hit) begin
          idx_q    <= req_index;
          tag_q    <= req_tag;
          vtag_q   <= vtag;
          vway_q   <= vway;
          vdirty_q <= vdirty;
          vdata_q  <= victim_data_in;
          state    <= vdirty ? WB_REQ : FILL_REQ;
        end
        WB_REQ:    if (mem_req_ready)  state <= WB_WAIT;
        WB_WAIT:   if (mem_resp_valid) state <= FILL_REQ;
        FILL_REQ:  if (mem_req_ready)  state <= FILL_WAIT;
        FILL_WAIT: if (mem_resp_valid) begin
          fdata_q <= mem_resp_data;
          state   <= FILL_WRITE;
        end
        FILL_WRITE: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state and latched fields, so they are zero in IDLE.
  always_comb begin
    busy          = (state != IDLE);
    mem_req_valid = (state == WB_REQ) || (state == FILL_REQ);
    mem_req_rw    = (state == WB_REQ);
    mem_req_addr  = '0;
    mem_req_data  = '0;
    if (state == WB_REQ) begin
      mem_req_addr = {vtag_q, idx_q};
      mem_req_data = vdata_q;
    end else if (state == FILL_REQ) begin
      mem_req_addr = {tag_q, idx_q};
    end
    fill_valid = (state == FILL_WRITE);
    fill_way   = fill_valid ? vway_q  : '0;
    fill_index = fill_valid ? idx_q   : '0;
    fill_tag   = fill_valid ? tag_q   : '0;
    fill_data  = fill_valid ? fdata_q : '0;
    fill_meta  = fill_valid ? 8'h02   : 8'h00;
  end

  logic unused_dirty;
  assign unused_dirty = vdirty_q;
endmodule

// File: tb/tb_cache_miss_handler.sv
module tb_cache_miss_handler;
  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, hit;
  logic [5:0]   req_index;
  logic [19:0]  req_tag;
  logic [3:0]   way_out;
  logic [79:0]  tag_cur_state;
  logic [31:0]  meta_in;
  logic [127:0] victim_data_in;
  logic         busy, mem_req_valid, mem_req_rw, mem_req_ready, mem_resp_valid;
  logic [25:0]  mem_req_addr;
  logic [127:0] mem_req_data, mem_resp_data, fill_data;
  logic         fill_valid;
  logic [3:0]   fill_way;
  logic [5:0]   fill_index;
  logic [19:0]  fill_tag;
  logic [7:0]   fill_meta;

  always #5 clk = ~clk;

  cache_miss_handler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_index(req_index), .req_tag(req_tag),
    .hit(hit), .way_out(way_out), .tag_cur_state(tag_cur_state), .meta_in(meta_in),
    .victim_data_in(victim_data_in), .busy(busy), .mem_req_valid(mem_req_valid),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .fill_valid(fill_valid), .fill_way(fill_way), .fill_index(fill_index), .fill_tag(fill_tag),
    .fill_data(fill_data), .fill_meta(fill_meta)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference PLRU: three tree bits per set, kept as separate flag arrays.
  bit mb0 [64];
  bit mb1 [64];
  bit mb2 [64];

  function automatic int mdl_victim(input int idx, input logic [31:0] meta);
    for (int w = 0; w < 4; w++) if (meta[8*w +: 4] == 4'd1) return w;
    if (!mb0[idx]) return mb1[idx] ? 1 : 0;
    return mb2[idx] ? 3 : 2;
  endfunction

  task automatic mdl_touch(input int idx, input int w);
    if (w < 2) begin mb0[idx] = 1'b1; mb1[idx] = (w == 0); end
    else       begin mb0[idx] = 1'b0; mb2[idx] = (w == 2); end
  endtask

  task automatic mdl_reset();
    for (int s = 0; s < 64; s++) begin mb0[s] = 0; mb1[s] = 0; mb2[s] = 0; end
  endtask

  task automatic do_hit(input logic [5:0] idx, input int w);
    req_valid = 1; hit = 1; req_index = idx; way_out = 4'b0001 << w;
    tick();
    req_valid = 0; hit = 0; way_out = 0;
    chk("hit_no_busy", busy, 0);
    chk("hit_no_memreq", mem_req_valid, 0);
  endtask

  // One full miss transaction; DUT must be IDLE on entry. Memory timing is
  // driven here and every cycle's outputs are checked against expectations.
  task automatic run_miss(input logic [5:0] idx, input logic [19:0] tg, input logic [31:0] meta,
                          input logic [79:0] tags, input logic [127:0] vdata, input logic [127:0] rdata,
                          input int rdly, input int fdly, input int exp_way, input bit exp_dirty,
                          input logic [19:0] exp_vtag, input bit hold, input logic [3:0] hold_way);
    logic [3:0] ew;
    ew = 4'b0001 << exp_way;
    chk("pre_busy", busy, 0);
    req_valid = 1; hit = 0; way_out = 0; req_index = idx; req_tag = tg;
    meta_in = meta; tag_cur_state = tags; victim_data_in = vdata;
    tick();
    // Scramble the lookup inputs: the DUT must work from its latched copies.
    req_valid = hold; hit = 1; way_out = hold_way;
    meta_in = $urandom; tag_cur_state = {$urandom, $urandom, $urandom};
    victim_data_in = ~vdata; req_tag = ~tg;
    chk("accept_busy", busy, 1);
    if (exp_dirty) begin
      mem_req_ready = 0;
      for (int c = 0; c <= rdly; c++) begin
        if (c == rdly) mem_req_ready = 1;
        chk("wb_valid", mem_req_valid, 1);
        chk("wb_rw", mem_req_rw, 1);
        chk("wb_addr", mem_req_addr, {exp_vtag, idx});
        chk("wb_data", mem_req_data, vdata);
        chk("wb_no_fill", fill_valid, 0);
        tick();
      end
      mem_req_ready = 0;
      chk("wbwait_noreq", mem_req_valid, 0);
      tick();
      chk("wbwait_busy", busy, 1);
      mem_resp_valid = 1; mem_resp_data = ~rdata;
      tick();
      mem_resp_valid = 0;
    end
    chk("fr_valid", mem_req_valid, 1);
    chk("fr_rw", mem_req_rw, 0);
    chk("fr_addr", mem_req_addr, {tg, idx});
    chk("fr_data", mem_req_data, 0);
    chk("fr_no_fill", fill_valid, 0);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    for (int c = 0; c < fdly; c++) begin
      chk("fw_noreq", mem_req_valid, 0);
      chk("fw_no_fill", fill_valid, 0);
      tick();
    end
    chk("fw_noreq", mem_req_valid, 0);
    mem_resp_valid = 1; mem_resp_data = rdata;
    tick();
    mem_resp_valid = 0; mem_resp_data = $urandom;
    req_valid = 0;
    chk("fill_valid", fill_valid, 1);
    chk("fill_way", fill_way, ew);
    chk("fill_index", fill_index, idx);
    chk("fill_tag", fill_tag, tg);
    chk("fill_data", fill_data, rdata);
    chk("fill_meta", fill_meta, 8'h02);
    chk("fill_busy", busy, 1);
    tick();
    chk("post_fill_valid", fill_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_noreq", mem_req_valid, 0);
  endtask

  typedef struct {
    bit           is_hit;
    logic [5:0]   idx;
    logic [19:0]  tag;
    logic [31:0]  meta;
    logic [79:0]  tags;
    logic [127:0] vdata;
    logic [127:0] rdata;
    int           rdly;
    int           way;
    bit           dirty;
    logic [19:0]  vtag;
  } vec_t;

  function automatic vec_t mk(input bit h, input logic [5:0] i, input logic [19:0] t, input logic [31:0] m,
                              input logic [79:0] tg, input logic [127:0] vd, input logic [127:0] rd,
                              input int rl, input int w, input bit d, input logic [19:0] vt);
    vec_t v;
    v.is_hit = h; v.idx = i; v.tag = t; v.meta = m; v.tags = tg; v.vdata = vd; v.rdata = rd;
    v.rdly = rl; v.way = w; v.dirty = d; v.vtag = vt;
    return v;
  endfunction

  vec_t tbl [6];

  initial begin
    logic [79:0] tg3;
    tg3 = {20'h33333, 20'h22222, 20'h11111, 20'hABCDE};
    // Hits on set 5 to ways 0,2,1 leave the tree pointing at way3.
    tbl[0] = mk(1, 6'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 6'd5, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    tbl[2] = mk(1, 6'd5, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[3] = mk(0, 6'd5, 20'h11111, 32'h02020202, {20'h0D, 20'h0C, 20'h0B, 20'h0A},
                128'h1111_2222_3333_4444, 128'h5555_6666_7777_8888, 0, 3, 0, 20'h0D);
    tbl[4] = mk(0, 6'd0, 20'h0BEEF, 32'h02010102, {20'h4, 20'h3, 20'h2, 20'h1},
                128'h9999, 128'hAAAA_BBBB, 0, 1, 0, 20'h2);
    tbl[5] = mk(0, 6'd3, 20'h12345, 32'h02020203, tg3,
                128'hCAFE_F00D_0123_4567, 128'hDEAD_BEEF, 4, 0, 1, 20'hABCDE);

    rst = 1; req_valid = 0; hit = 0; req_index = 0; req_tag = 0; way_out = 0;
    tag_cur_state = 0; meta_in = 0; victim_data_in = 0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_data = 0;
    mdl_reset();
    tick(); tick();
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_memreq", {mem_req_valid, mem_req_rw, mem_req_addr}, 0);
    chk("rst_memdata", mem_req_data, 0);
    chk("rst_fill", {fill_valid, fill_way, fill_index, fill_tag, fill_meta}, 0);
    chk("rst_filldata", fill_data, 0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].is_hit) begin
        do_hit(tbl[i].idx, tbl[i].way);
        mdl_touch(tbl[i].idx, tbl[i].way);
      end else begin
        run_miss(tbl[i].idx, tbl[i].tag, tbl[i].meta, tbl[i].tags, tbl[i].vdata, tbl[i].rdata,
                 tbl[i].rdly, 0, tbl[i].way, tbl[i].dirty, tbl[i].vtag, 0, 4'b0000);
        mdl_touch(tbl[i].idx, tbl[i].way);
      end
    end

    // Stray response in IDLE must do nothing.
    mem_resp_valid = 1; mem_resp_data = 128'hBAD;
    tick(); tick();
    mem_resp_valid = 0;
    chk("stray_busy", busy, 0);
    chk("stray_noreq", mem_req_valid, 0);
    chk("stray_nofill", fill_valid, 0);

    // Hit to way2 held on set 10 through a whole miss must not touch PLRU:
    // after the way0 fill the next victim is way2 (it would be way3 otherwise).
    run_miss(6'd10, 20'h0AAAA, 32'h02020202, 80'h0, 128'h77, 128'h88, 0, 1, 0, 0, 20'h0, 1, 4'b0100);
    mdl_touch(10, 0);
    run_miss(6'd10, 20'h0BBBB, 32'h02020202, 80'h0, 128'h66, 128'h99, 0, 0, 2, 0, 20'h0, 0, 4'b0000);
    mdl_touch(10, 2);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      int idx, w;
      idx = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 0) begin
        w = $urandom_range(0, 3);
        do_hit(idx[5:0], w);
        mdl_touch(idx, w);
      end else begin
        logic [31:0] m;
        logic [79:0] tg;
        logic [127:0] vd, rd;
        bit d;
        for (int k = 0; k < 4; k++) begin
          m[8*k +: 4]   = 4'($urandom_range(1, 3));
          m[8*k+4 +: 4] = 4'($urandom);
        end
        tg = {$urandom, $urandom, $urandom};
        vd = {$urandom, $urandom, $urandom, $urandom};
        rd = {$urandom, $urandom, $urandom, $urandom};
        w = mdl_victim(idx, m);
        d = (m[8*w +: 4] == 4'd3);
        run_miss(idx[5:0], 20'($urandom), m, tg, vd, rd, $urandom_range(0, 3), $urandom_range(0, 2),
                 w, d, tg[20*w +: 20], 0, 4'b0000);
        mdl_touch(idx, w);
      end
    end

    // Reset while waiting for fill data abandons the miss.
    req_valid = 1; hit = 0; req_index = 6'd20; req_tag = 20'h0F0F0; meta_in = 32'h02020202;
    tick();
    req_valid = 0;
    chk("rr_fillreq", mem_req_valid, 1);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    chk("rr_fillwait", {busy, mem_req_valid}, 2'b10);
    #2 rst = 1;
    #1;
    chk("rr_async_busy", busy, 0);
    chk("rr_async_noreq", mem_req_valid, 0);
    mem_resp_valid = 1; mem_resp_data = 128'h1234;
    tick();
    rst = 0;
    mdl_reset();
    for (int c = 0; c < 4; c++) begin
      chk("rr_nofill", fill_valid, 0);
      chk("rr_idle", {busy, mem_req_valid}, 0);
      tick();
    end
    mem_resp_valid = 0;
    // Reset cleared set 5's tree, so an all-clean miss picks way0 again.
    run_miss(6'd5, 20'h0C0C0, 32'h02020202, 80'h0, 128'h5, 128'h6, 0, 0, 0, 0, 20'h0, 0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
